// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI slave receive buffer.
// Pure definitions: no latency, no flow control.
package spi_rx_pkg;
  localparam int WORD_W = 16;
  localparam int AW_DEF = 4;

  // Occupancy of a circular buffer whose pointers carry one extra wrap bit.
  function automatic int unsigned ptr_level(input int unsigned wp, input int unsigned rp,
                                            input int aw);
    int unsigned one;
    one = 1;
    return (wp - rp) & ((one << (aw + 1)) - one);
  endfunction
endpackage

// File: rtl/spi_rx_ram.sv
// Simple dual-port word store, one write and one registered read per clk (1-cycle read).
// No backpressure; read output holds its value when i_re is low.
module spi_rx_ram
  import spi_rx_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [2**AW];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read-before-write: a same-address write this cycle returns the old word.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)   r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/spi_rx_fifo_ctl.sv
// Lapping receive FIFO for SPI words: 1-cycle read latency; never stalls the writer, overflow drops
// all stale words and keeps the newest. Optional level irq via SPI_RX_FIFO_IRQ_EN.
module spi_rx_fifo_ctl
  import spi_rx_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              rd,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  input  logic              clr_overrun,
  input  logic              flush,
  output logic              irq
);
  localparam int DEPTH = 2**AW;

  logic [AW:0] r_wptr, r_rptr;
  logic [AW:0] w_wptr_nxt, w_rptr_nxt;
  logic        w_lap, w_re;

  assign level = (AW+1)'(ptr_level(32'(r_wptr), 32'(r_rptr), AW));
  assign empty = (r_wptr == r_rptr);
  assign full  = (level == (AW+1)'(DEPTH));

  // A simultaneous read makes room, so only an unread write into a full buffer laps.
  assign w_lap = in_valid && full && !rd && !flush;
  assign w_re  = rd && !empty && !flush;

  always_comb begin
    w_rptr_nxt = r_rptr;
    if (flush || w_lap) w_rptr_nxt = r_wptr;
    else if (w_re)      w_rptr_nxt = r_rptr + 1'b1;
    w_wptr_nxt = in_valid ? r_wptr + 1'b1 : r_wptr;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      rd_valid <= w_re;
      if (w_lap)            overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  spi_rx_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .resetq  (resetq),
    .i_we    (in_valid),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (in_data),
    .i_re    (w_re),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (rd_data)
  );

`ifdef SPI_RX_FIFO_IRQ_EN
  logic [AW:0] w_level_nxt;
  logic        r_irq;

  assign w_level_nxt = (AW+1)'(ptr_level(32'(w_wptr_nxt), 32'(w_rptr_nxt), AW));

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_irq <= 1'b0;
    else         r_irq <= (32'(w_level_nxt) >= 32'(THRESH));
  end

  assign irq = r_irq;
`else
  // THRESH has no effect in this build; the term folds to a constant zero.
  assign irq = (THRESH < 0) & 1'b0;
`endif
endmodule

// File: tb/tb_spi_rx_fifo_ctl.sv
// Randomized bench for spi_rx_fifo_ctl against a queue-based model of the lapping FIFO.
module tb_spi_rx_fifo_ctl;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        rd = 1'b0;
  logic        clr_overrun = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [AW:0] level;
  logic        empty, full, overrun, irq;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] mq[$];
  logic [15:0] m_data = '0;
  logic        m_vld  = 1'b0;
  logic        m_ov   = 1'b0;

  spi_rx_fifo_ctl #(.AW(AW), .THRESH(THRESH)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .rd          (rd),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .flush       (flush),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_irq();
`ifdef SPI_RX_FIFO_IRQ_EN
    return mq.size() >= THRESH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    chk("rd_valid", 32'(rd_valid), 32'(m_vld));
    chk("rd_data",  32'(rd_data),  32'(m_data));
    chk("level",    32'(level),    32'(mq.size()));
    chk("empty",    32'(empty),    32'(mq.size() == 0));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("overrun",  32'(overrun),  32'(m_ov));
    chk("irq",      32'(irq),      32'(exp_irq()));
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, then compare.
  task automatic step(input logic iv, input logic [15:0] d, input logic r,
                      input logic f, input logic c);
    int  n;
    logic lap;
    in_valid = iv; in_data = d; rd = r; flush = f; clr_overrun = c;
    @(posedge clk);
    n = mq.size();
    lap = 1'b0;
    m_vld = 1'b0;
    if (f) begin
      mq.delete();
      if (iv) mq.push_back(d);
    end else begin
      if (r && n > 0) begin
        m_data = mq.pop_front();
        m_vld = 1'b1;
      end
      if (iv) begin
        if (n == DEPTH && !r) begin
          mq.delete();
          lap = 1'b1;
        end
        mq.push_back(d);
      end
    end
    if (lap)    m_ov = 1'b1;
    else if (c) m_ov = 1'b0;
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #1 resetq = 1'b0;
    #1;
    chk("rst_rd_data",  32'(rd_data),  32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_level",    32'(level),    32'h0);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_overrun",  32'(overrun),  32'h0);
    chk("rst_irq",      32'(irq),      32'h0);
    #1 resetq = 1'b1;
    mq.delete();
    m_data = '0; m_vld = 1'b0; m_ov = 1'b0;
  endtask

  initial begin
    logic        iv, r, f, c;
    logic [15:0] d;
    int          p_wr;

    #1;
    check_all();
    #11 resetq = 1'b1;

    step(1, 16'h1234, 0, 0, 0);
    step(1, 16'hABCD, 0, 0, 0);
    chk("p1_lvl2", 32'(level), 32'd2);
    step(0, 16'h0, 1, 0, 0);
    chk("p1_rd0", 32'(rd_data), 32'h1234);
    chk("p1_vld0", 32'(rd_valid), 32'h1);
    step(0, 16'h0, 1, 0, 0);
    chk("p1_rd1", 32'(rd_data), 32'hABCD);
    chk("p1_empty", 32'(empty), 32'h1);
    step(0, 16'h0, 0, 0, 0);
    chk("p1_vld_pulse", 32'(rd_valid), 32'h0);

    for (int i = 0; i < 16; i++) step(1, 16'(i), 0, 0, 0);
    chk("p2_full", 32'(full), 32'h1);
    chk("p2_lvl16", 32'(level), 32'd16);
    step(1, 16'h00FF, 0, 0, 0);
    chk("p2_lap_lvl", 32'(level), 32'd1);
    chk("p2_lap_ov", 32'(overrun), 32'h1);
    step(0, 16'h0, 1, 0, 0);
    chk("p2_lap_rd", 32'(rd_data), 32'h00FF);
    chk("p2_empty", 32'(empty), 32'h1);

    step(0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 16'(i), 0, 0, 0);
    step(1, 16'h5555, 1, 0, 0);
    chk("p3_rd_old", 32'(rd_data), 32'h0000);
    chk("p3_lvl", 32'(level), 32'd16);
    chk("p3_ov", 32'(overrun), 32'h0);

    step(0, 16'h0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
    step(1, 16'h7777, 0, 1, 0);
    chk("p4_lvl1", 32'(level), 32'd1);
    step(0, 16'h0, 1, 0, 0);
    chk("p4_rd", 32'(rd_data), 32'h7777);
    step(0, 16'h0, 1, 0, 0);
    chk("p4_rd_empty", 32'(rd_valid), 32'h0);

    for (int i = 0; i < 40; i++) begin
      step(1, 16'h1000 + 16'(i), 0, 0, 0);
      step(0, 16'h0, 1, 0, 0);
      chk("p5_wrap", 32'(rd_data), 32'h1000 + 32'(i));
    end

    for (int i = 0; i < 16; i++) step(1, 16'h2000 + 16'(i), 0, 0, 0);
    step(1, 16'h2EEE, 0, 0, 1);
    chk("p5_set_wins", 32'(overrun), 32'h1);

`ifdef SPI_RX_FIFO_IRQ_EN
    step(0, 16'h0, 0, 1, 1);
    for (int i = 0; i < 7; i++) step(1, 16'h3000 + 16'(i), 0, 0, 0);
    chk("p6_irq_lo", 32'(irq), 32'h0);
    step(1, 16'h3007, 0, 0, 0);
    chk("p6_irq_hi", 32'(irq), 32'h1);
    step(0, 16'h0, 1, 0, 0);
    chk("p6_irq_drop", 32'(irq), 32'h0);
`endif

    for (int i = 0; i < 2000; i++) begin
      p_wr = ((i / 250) % 2 == 1) ? 75 : 35;
      iv = ($urandom_range(0, 99) < p_wr);
      r  = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 3);
      c  = ($urandom_range(0, 99) < 5);
      d  = 16'($urandom);
      step(iv, d, r, f, c);
      if (i == 1100) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_rx_fifo_ctl.md
Name: spi_rx_fifo_ctl

Overview:
Receive-side buffer controller for the SPI slave word receiver. It sits in the CPU `clk` domain after the receiver's double-registered word output and its one-cycle write strobe. It queues received 16-bit words in a small circular buffer for the j1a I/O read port. On overflow it "laps": stale data is discarded and the newest word is kept, because freshness matters more than completeness for this data channel.

Parameters:
AW, 4, address width; depth DEPTH = 2**AW words (default 16)
THRESH, 8, level at or above which irq asserts (only used with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
resetq  input  1  asynchronous active-low reset
in_data  input  16  received word, valid when in_valid=1
in_valid  input  1  one-cycle write strobe from the receiver CDC stage
rd  input  1  CPU read strobe, pops the oldest word
rd_data  output  16  popped word, registered
rd_valid  output  1  one-cycle pulse, rd_data valid
level  output  AW+1  words currently held, 0..DEPTH
empty  output  1  level==0
full  output  1  level==DEPTH
overrun  output  1  sticky flag, set when a lap occurred
clr_overrun  input  1  clears overrun
flush  input  1  discard all held words
irq  output  1  level>=THRESH (see Optional Feature)

Behaviour:
- Storage: DEPTH x 16 circular array with synchronous read. Pointers wptr and rptr are each AW+1 bits, wrap naturally mod 2**(AW+1).
- Flag derivation: level = wptr-rptr; empty = (wptr==rptr); full = (level==DEPTH). All three derive only from registered pointers, with no combinational path from inputs.
- Reset (resetq low, async): wptr=rptr=0, rd_data=0, rd_valid=0, overrun=0, irq=0. Reset mid-transfer discards contents; the first write after release lands at address 0.
- Write, in_valid=1 and not full: mem[wptr]<=in_data; wptr+1.
- Lap, in_valid=1 and full and rd=0:
  - rptr<=wptr, then the word is written at wptr and wptr+1.
  - level becomes 1 next cycle; overrun<=1.
- Read, rd=1 and not empty: rd_data<=mem[rptr] one cycle later; rd_valid=1 for exactly that cycle; rptr+1. Read latency is 1 cycle.
- rd=1 when empty: ignored. No pointer change, rd_valid=0, rd_data holds its previous value.
- Simultaneous in_valid and rd:
  - When full: normal read plus normal write, no lap, overrun unchanged, level stays DEPTH.
  - When empty: write only; rd is ignored (no fall-through).
  - Otherwise: both occur and level is unchanged.
- flush=1: rptr<=wptr, and any rd that cycle is ignored.
  - If in_valid is also 1, the new word is kept: level=1 next cycle.
  - flush never sets overrun.
- overrun: set has priority over clr_overrun in the same cycle.
- Back-to-back in_valid on consecutive cycles must be accepted, although the receiver spaces writes by at least 16 SCL periods.

Optional Feature:
Macro SPI_RX_FIFO_IRQ_EN.
- Defined: irq is a register updated every cycle to (next level >= THRESH). It therefore asserts the cycle after the write that reaches THRESH and deasserts the cycle after the read that drops below it. A lap forces it low if THRESH>1.
- Undefined: irq is tied to 0, THRESH is unused, and no extra registers are present. The port list is identical in both cases.

Decomposition:
- Shared package/header spi_rx_pkg: WORD_W=16, default AW, pointer-difference helper.
- One sub-module, spi_rx_ram: simple dual-port, 16-bit, write on clk and synchronous registered read. It is written so synthesis maps it to one SB_RAM40_4K (256x16, upper address bits zero).
- Pointer, flag, lap and irq logic stay in spi_rx_fifo_ctl.

Test Plan:
- Reset then write 0x1234, 0xABCD; rd twice -> rd_data 0x1234 then 0xABCD, each with a 1-cycle rd_valid one cycle after rd; level goes 2->0; empty=1.
- Write 0x0000..0x000F (16 words) -> full=1, level=16. Write 0x00FF -> level=1, overrun=1; rd -> 0x00FF; empty=1.
- With full=1, assert in_valid=0x5555 and rd together -> rd_data=0x0000 (oldest), level stays 16, overrun stays 0.
- 3 words held, flush with in_valid=0x7777 same cycle -> level=1; rd -> 0x7777. Then rd on empty -> rd_valid stays 0.
- Pointer wrap: 40 write/read pairs -> every word returned in order across the 32-count pointer wrap. Assert clr_overrun in the same cycle as a lap -> overrun=1.
- With SPI_RX_FIFO_IRQ_EN and THRESH=8: 8th write -> irq=1 next cycle; one rd -> irq=0. Async resetq pulse mid-stream -> all outputs at reset values immediately.
